uart_rx_ctrl: RTL and testbench

Sequencing and buffering controller for the UART receiver. Holds the receiver's baud prescaler configuration and drives the receiver's reset, so the receiver is always restarted cleanly on enable or reconfiguration. Captures received bytes into a small show-ahead FIFO with a valid/ready output stream. Tracks framing errors and overruns as sticky status bits.

---
 rtl/uart_rx_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Sequencing/buffering controller for the UART receiver: receiver reset sequencing,
// prescaler register, show-ahead byte FIFO and sticky status. Optional: UART_RX_CTRL_STATS_EN.
module uart_rx_ctrl #(
  parameter int FIFO_AW       = 3,
  parameter int HOLD_CYCLES   = 4,
  parameter int PRESCALER_RST = 104
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cfg_wr,
  input  logic [20:0]        cfg_prescaler,
  input  logic               cfg_flush,
  input  logic               clr_status,
  output logic               rx_rst_n,
  output logic [20:0]        prescaler,
  input  logic               rx_ready,
  input  logic [7:0]         rx_data,
  input  logic               framing_error,
  output logic               m_valid,
  output logic [7:0]         m_data,
  input  logic               m_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overrun,
  output logic               frame_err,
  output logic [15:0]        frame_err_count,
  output logic [15:0]        overrun_count,
  output logic [15:0]        byte_count
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [3:0]         HOLD_INIT  = 4'(HOLD_CYCLES);
  localparam logic [20:0]        PRESC_INIT = 21'(PRESCALER_RST);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW + 1)'(1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         hold_cnt_q, hold_cnt_d;
  logic [20:0]        prescaler_q, prescaler_d;
  logic               rdy_prev_q, fe_prev_q;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [7:0]         mem_q [DEPTH];

  logic push, fe_evt, pop, full, wr_en, drop;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    prescaler_d = prescaler_q;
    if (cfg_wr) prescaler_d = (cfg_prescaler < 21'd2) ? 21'd2 : cfg_prescaler;

    case (state_q)
      ST_OFF: begin
        if (enable) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (!enable)     state_d = ST_OFF;
        else if (cfg_wr) hold_cnt_d = HOLD_INIT;
        // Leave on the cycle the count would reach zero: exactly HOLD_CYCLES cycles in HOLD.
        else if (hold_cnt_q <= 4'd1) begin
          state_d    = ST_RUN;
          hold_cnt_d = 4'd0;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_OFF;
        else if (cfg_wr) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_INIT;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    push   = (state_q == ST_RUN) && rx_ready && !rdy_prev_q;
    fe_evt = (state_q == ST_RUN) && framing_error && !fe_prev_q;
    pop    = m_valid && m_ready;
    full   = level_q[FIFO_AW];

    wr_en    = 1'b0;
    drop     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (cfg_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // When full, a same-cycle pop frees the slot the push writes into.
      wr_en = push && (!full || pop);
      drop  = push && full && !pop;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_en && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !wr_en) level_d = level_q - LVL_ONE;
    end

    overrun_d   = drop   || (overrun_q   && !clr_status);
    frame_err_d = fe_evt || (frame_err_q && !clr_status);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      hold_cnt_q  <= 4'd0;
      prescaler_q <= PRESC_INIT;
      rdy_prev_q  <= 1'b0;
      fe_prev_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      prescaler_q <= prescaler_d;
      rdy_prev_q  <= rx_ready;
      fe_prev_q   <= framing_error;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: the storage array has no reset; the level counter alone decides which
  // entries are meaningful, and an unreset array maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rx_rst_n   = (state_q == ST_RUN);
  assign prescaler  = prescaler_q;
  assign m_valid    = (level_q != '0);
  assign m_data     = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] fe_cnt_q, fe_cnt_d, ovr_cnt_q, ovr_cnt_d, byte_cnt_q, byte_cnt_d;

  // Clear wins over the old value but not over a same-cycle increment.
  function automatic logic [15:0] next_count(input logic [15:0] cnt, input logic inc,
                                             input logic clr);
    if (clr) return {15'd0, inc};
    if (inc && cnt != 16'hFFFF) return cnt + 16'd1;
    return cnt;
  endfunction

  always_comb begin
    fe_cnt_d   = next_count(fe_cnt_q,   fe_evt, clr_status);
    ovr_cnt_d  = next_count(ovr_cnt_q,  drop,   clr_status);
    byte_cnt_d = next_count(byte_cnt_q, wr_en,  clr_status);
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      fe_cnt_q   <= 16'd0;
      ovr_cnt_q  <= 16'd0;
      byte_cnt_q <= 16'd0;
    end else begin
      fe_cnt_q   <= fe_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign frame_err_count = fe_cnt_q;
  assign overrun_count   = ovr_cnt_q;
  assign byte_count      = byte_cnt_q;
`else
  assign frame_err_count = 16'd0;
  assign overrun_count   = 16'd0;
  assign byte_count      = 16'd0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;

  localparam int FIFO_AW   = 3;
  localparam int DEPTH     = 8;
  localparam int HOLD      = 4;
  localparam int PRESC_RST = 104;
`ifdef UART_RX_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              CLK;
  logic              rst_n;
  logic              enable, cfg_wr, cfg_flush, clr_status;
  logic [20:0]       cfg_prescaler;
  logic              rx_rst_n;
  logic [20:0]       prescaler;
  logic              rx_ready, framing_error, m_ready, m_valid;
  logic [7:0]        rx_data, m_data;
  logic [FIFO_AW:0]  fifo_level;
  logic              overrun, frame_err;
  logic [15:0]       frame_err_count, overrun_count, byte_count;

  uart_rx_ctrl #(.FIFO_AW(FIFO_AW), .HOLD_CYCLES(HOLD), .PRESCALER_RST(PRESC_RST)) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_prescaler(cfg_prescaler), .cfg_flush(cfg_flush), .clr_status(clr_status),
    .rx_rst_n(rx_rst_n), .prescaler(prescaler), .rx_ready(rx_ready), .rx_data(rx_data),
    .framing_error(framing_error), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .fifo_level(fifo_level), .overrun(overrun), .frame_err(frame_err),
    .frame_err_count(frame_err_count), .overrun_count(overrun_count), .byte_count(byte_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: receiver is running once it has been on for HOLD cycles
  // without a reconfiguration; the FIFO is just a queue of bytes.
  bit         m_on;
  int         m_rem;
  int         m_presc;
  logic [7:0] q[$];
  bit         m_ovr, m_fe, m_prev_rdy, m_prev_fe;
  int         c_fe, c_ovr, c_byte;

  function automatic void model_reset();
    m_on = 0; m_rem = 0; m_presc = PRESC_RST; q.delete();
    m_ovr = 0; m_fe = 0; m_prev_rdy = 0; m_prev_fe = 0;
    c_fe = 0; c_ovr = 0; c_byte = 0;
  endfunction

  function automatic int bump(input int c, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc && c < 65535) return c + 1;
    return c;
  endfunction

  task automatic model_step();
    bit running, push, fe, pop, full, accepted, drop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    running  = m_on && (m_rem == 0);
    push     = running && rx_ready && !m_prev_rdy;
    fe       = running && framing_error && !m_prev_fe;
    pop      = (q.size() != 0) && m_ready;
    full     = (q.size() == DEPTH);
    accepted = 0;
    drop     = 0;
    if (cfg_flush) q.delete();
    else begin
      if (pop) q.delete(0);
      if (push) begin
        if (!full || pop) begin
          q.push_back(rx_data);
          accepted = 1;
        end else drop = 1;
      end
    end
    m_ovr  = drop || (m_ovr && !clr_status);
    m_fe   = fe   || (m_fe  && !clr_status);
    c_fe   = bump(c_fe,   fe,       clr_status);
    c_ovr  = bump(c_ovr,  drop,     clr_status);
    c_byte = bump(c_byte, accepted, clr_status);
    m_prev_rdy = rx_ready;
    m_prev_fe  = framing_error;
    if (cfg_wr) m_presc = (cfg_prescaler < 21'd2) ? 2 : int'(cfg_prescaler);
    if (!enable)     m_on = 0;
    else if (!m_on) begin
      m_on  = 1;
      m_rem = HOLD;
    end
    else if (cfg_wr)    m_rem = HOLD;
    else if (m_rem > 0) m_rem--;
  endtask

  task automatic check_outputs();
    check("rx_rst_n",   rx_rst_n,   (m_on && m_rem == 0));
    check("prescaler",  prescaler,  m_presc);
    check("m_valid",    m_valid,    (q.size() != 0));
    check("fifo_level", fifo_level, q.size());
    if (q.size() != 0) check("m_data", m_data, q[0]);
    check("overrun",    overrun,    m_ovr);
    check("frame_err",  frame_err,  m_fe);
    check("fe_count",   frame_err_count, STATS ? c_fe   : 0);
    check("ovr_count",  overrun_count,   STATS ? c_ovr  : 0);
    check("byte_count", byte_count,      STATS ? c_byte : 0);
  endtask

  // Inputs are set 1 time unit after a rising edge; outputs compared then too.
  task automatic tick();
    check_outputs();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic wait_run_checked(input string tag);
    for (int i = 0; i < HOLD; i++) begin
      check({tag, "_low"}, rx_rst_n, 1'b0);
      tick();
    end
    check({tag, "_high"}, rx_rst_n, 1'b1);
  endtask

  logic [7:0] exp_b;

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_wr = 1'b0; cfg_prescaler = '0; cfg_flush = 1'b0;
    clr_status = 1'b0; rx_ready = 1'b0; rx_data = '0; framing_error = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Reset state
    check("rst_rx_rst_n", rx_rst_n, 1'b0);
    check("rst_prescaler", prescaler, 21'd104);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_level", fifo_level, 4'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_counts", {frame_err_count, overrun_count | byte_count}, 32'd0);

    // Power-up: receiver held in reset for HOLD cycles after enable
    repeat (8) tick();
    enable = 1'b1;
    tick();
    wait_run_checked("powerup");
    check("powerup_presc", prescaler, 21'd104);

    // Reconfigure with a value below the minimum
    cfg_wr = 1'b1;
    cfg_prescaler = 21'd1;
    tick();
    cfg_wr = 1'b0;
    check("reconf_clamp", prescaler, 21'd2);
    wait_run_checked("reconf");

    // Fill to full, then one more byte overruns
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("full_level", fifo_level, 4'd8);
    check("full_no_ovr", overrun, 1'b0);
    push_byte(8'h09);
    check("ovr_level", fifo_level, 4'd8);
    check("ovr_set", overrun, 1'b1);
    check("ovr_cnt", overrun_count, STATS ? 16'd1 : 16'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", m_data, 8'(i + 1));
      tick();
    end
    m_ready = 1'b0;
    check("drain_empty", m_valid, 1'b0);

    // Push and pop in the same cycle while full
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_ovr", overrun, 1'b0);
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
    rx_ready = 1'b1;
    rx_data  = 8'hAA;
    m_ready  = 1'b1;
    check("pp_head", m_data, 8'h10);
    tick();
    rx_ready = 1'b0;
    m_ready  = 1'b0;
    check("pp_level", fifo_level, 4'd8);
    check("pp_no_ovr", overrun, 1'b0);
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(8'h11 + i) : 8'hAA;
      check("pp_drain", m_data, exp_b);
      tick();
    end
    m_ready = 1'b0;

    // Flush in the same cycle as a push
    push_byte(8'h55);
    rx_ready  = 1'b1;
    rx_data   = 8'h66;
    cfg_flush = 1'b1;
    tick();
    rx_ready  = 1'b0;
    cfg_flush = 1'b0;
    check("flush_level", fifo_level, 4'd0);
    check("flush_valid", m_valid, 1'b0);
    check("flush_ovr", overrun, 1'b0);
    tick();

    // Framing errors: counted in RUN, ignored while off, then cleared
    framing_error = 1'b1;
    tick();
    framing_error = 1'b0;
    check("fe_set", frame_err, 1'b1);
    check("fe_cnt", frame_err_count, STATS ? 16'd1 : 16'd0);
    tick();
    enable = 1'b0;
    tick();
    check("off_rx_rst_n", rx_rst_n, 1'b0);
    framing_error = 1'b1;
    tick();
    framing_error = 1'b0;
    tick();
    check("fe_off_cnt", frame_err_count, STATS ? 16'd1 : 16'd0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_fe", frame_err, 1'b0);
    check("clr_counts", {frame_err_count, overrun_count | byte_count}, 32'd0);

    // Reset in the middle of operation
    enable = 1'b1;
    repeat (HOLD + 1) tick();
    push_byte(8'h3C);
    check("mid_level", fifo_level, 4'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_level", fifo_level, 4'd0);
    check("mid_rst_rx", rx_rst_n, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n         = ($urandom_range(0, 999) != 0);
      enable        = ($urandom_range(0, 99) != 0);
      cfg_wr        = ($urandom_range(0, 59) == 0);
      cfg_prescaler = ($urandom_range(0, 3) == 0) ? 21'($urandom_range(0, 3)) : 21'($urandom);
      cfg_flush     = ($urandom_range(0, 49) == 0);
      clr_status    = ($urandom_range(0, 39) == 0);
      rx_ready      = ($urandom_range(0, 2) == 0);
      rx_data       = 8'($urandom);
      framing_error = ($urandom_range(0, 11) == 0);
      m_ready       = ((i / 500) % 2 == 1) ? ($urandom_range(0, 1) == 1)
                                           : ($urandom_range(0, 4) == 0);
      tick();
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
